// File: rtl/sub_bytes_seq.sv
// Sequential AES SubBytes engine: LANES S-boxes per cycle, 16/LANES beats per state.
// Optional inverse S-box when SUB_BYTES_SEQ_INV_SBOX_EN is defined.
module sub_bytes_seq #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
`ifdef SUB_BYTES_SEQ_INV_SBOX_EN
    input  logic         inv,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int BEATS = 16 / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SUB  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_lanes_illegal
        $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
        logic [127:0] row;
        row = '0;
        case (b[7:4])
            4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
            4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
            4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
            4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
            4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
            4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
            4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
            4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
            4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
            4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
            4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
            4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
            4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
            4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
            4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
            4'hf: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
            default: row = '0;
        endcase
        // Column 0 sits in the top byte of each row constant.
        return row[{~b[3:0], 3'b000} +: 8];
    endfunction

`ifdef SUB_BYTES_SEQ_INV_SBOX_EN
    function automatic logic [7:0] sbox_inv(input logic [7:0] b);
        logic [127:0] row;
        row = '0;
        case (b[7:4])
            4'h0: row = 128'h52096ad53036a538bf40a39e81f3d7fb;
            4'h1: row = 128'h7ce339829b2fff87348e4344c4dee9cb;
            4'h2: row = 128'h547b9432a6c2233dee4c950b42fac34e;
            4'h3: row = 128'h082ea16628d924b2765ba2496d8bd125;
            4'h4: row = 128'h72f8f66486689816d4a45ccc5d65b692;
            4'h5: row = 128'h6c704850fdedb9da5e154657a78d9d84;
            4'h6: row = 128'h90d8ab008cbcd30af7e45805b8b34506;
            4'h7: row = 128'hd02c1e8fca3f0f02c1afbd0301138a6b;
            4'h8: row = 128'h3a9111414f67dcea97f2cfcef0b4e673;
            4'h9: row = 128'h96ac7422e7ad3585e2f937e81c75df6e;
            4'ha: row = 128'h47f11a711d29c5896fb7620eaa18be1b;
            4'hb: row = 128'hfc563e4bc6d279209adbc0fe78cd5af4;
            4'hc: row = 128'h1fdda8338807c731b11210592780ec5f;
            4'hd: row = 128'h60517fa919b54a0d2de57a9f93c99cef;
            4'he: row = 128'ha0e03b4dae2af5b0c8ebbb3c83539961;
            4'hf: row = 128'h172b047eba77d626e169146355210c7d;
            default: row = '0;
        endcase
        return row[{~b[3:0], 3'b000} +: 8];
    endfunction
`endif

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [127:0]     work_q,  work_d;
    logic             accept;
`ifdef SUB_BYTES_SEQ_INV_SBOX_EN
    logic             inv_q,   inv_d;
`endif

    assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign out_data  = work_q;
    assign accept    = in_valid && in_ready;

    always_comb begin
        // NOTE: every next-state variable gets a default first so no path infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
`ifdef SUB_BYTES_SEQ_INV_SBOX_EN
        inv_d   = inv_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_SUB;
            end
            S_SUB: begin
                for (int l = 0; l < LANES; l++) begin
                    logic [7:0] src;
                    logic [7:0] img;
                    src = work_q[127 - 8*(int'(cnt_q)*LANES + l) -: 8];
                    img = sbox_fwd(src);
`ifdef SUB_BYTES_SEQ_INV_SBOX_EN
                    if (inv_q) img = sbox_inv(src);
`endif
                    work_d[127 - 8*(int'(cnt_q)*LANES + l) -: 8] = img;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(BEATS - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = accept ? S_SUB : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // accept is only possible in IDLE or DONE, so this never overlaps a SUB beat.
        if (accept) begin
            work_d = in_data;
            cnt_d  = '0;
`ifdef SUB_BYTES_SEQ_INV_SBOX_EN
            inv_d  = inv;
`endif
        end
    end

    // NOTE: the working register is reset too, because it drives out_data directly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
`ifdef SUB_BYTES_SEQ_INV_SBOX_EN
            inv_q   <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments only.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
`ifdef SUB_BYTES_SEQ_INV_SBOX_EN
            inv_q   <= inv_d;
`endif
        end
    end

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Scoreboard bench for sub_bytes_seq: one DUT per legal LANES value, each with its own
// driver and monitor; reference S-box is derived from GF(2^8) inversion plus the affine map.
module tb_sub_bytes_seq;

    typedef struct packed {
        logic [127:0] data;
        int           cyc;
    } exp_t;

    logic clk;
    int   cyc;
    int   checks;
    int   failures;
    int   done_cnt;

    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine transform.
    initial begin
        for (int x = 0; x < 256; x++) begin
            logic [7:0] y, s;
            y = 8'h00;
            for (int c = 1; c < 256; c++)
                if (x != 0 && gmul(8'(x), 8'(c)) == 8'h01) y = 8'(c);
            s = y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
            fwd_tab[x] = s;
            inv_tab[s] = 8'(x);
        end
    end

    function automatic logic [127:0] ref_sub(input logic [127:0] d, input logic md);
        logic [127:0] r;
        logic [7:0]   b;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            b = d[127 - 8*i -: 8];
            r[127 - 8*i -: 8] = md ? inv_tab[b] : fwd_tab[b];
        end
        return r;
    endfunction

    task automatic check(input int lanes, input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL L%0d %s: got %h expected %h", lanes, name, act, exp);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        done_cnt = 0;
    end

    for (genvar g = 0; g < 5; g++) begin : g_lane
        localparam int L     = 1 << g;
        localparam int BEATS = 16 / L;

        logic         rst_n;
        logic         in_valid;
        logic         in_ready;
        logic [127:0] in_data;
        logic         out_valid;
        logic         out_ready;
        logic [127:0] out_data;
        logic         busy;
`ifdef SUB_BYTES_SEQ_INV_SBOX_EN
        logic         inv;
`endif
        exp_t         sb_q [$];

        sub_bytes_seq #(.LANES(L)) u_dut (
            .clk       (clk),
            .reset_n   (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_data   (in_data),
`ifdef SUB_BYTES_SEQ_INV_SBOX_EN
            .inv       (inv),
`endif
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_data  (out_data),
            .busy      (busy)
        );

        // Monitor: pops the expected result when a new output appears, then holds it to the protocol.
        initial begin
            logic         pend;
            logic [127:0] cur;
            exp_t         e;
            pend = 1'b0;
            cur  = '0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    pend = 1'b0;
                end else begin
                    if (busy && !out_valid) check(L, "in_ready_in_sub", in_ready, 0);
                    if (!busy) check(L, "idle_flags", {out_valid, in_ready}, 2'b01);
                    if (out_valid) check(L, "in_ready_in_done", in_ready, out_ready);
                    if (pend) check(L, "valid_held", out_valid, 1);
                    if (out_valid && !pend) begin
                        check(L, "output_expected", sb_q.size() != 0, 1);
                        if (sb_q.size() != 0) begin
                            e   = sb_q.pop_front();
                            cur = e.data;
                            check(L, "result", out_data, e.data);
                            check(L, "latency", cyc, e.cyc + BEATS);
                        end
                        pend = 1'b1;
                    end else if (out_valid) begin
                        check(L, "held_data", out_data, cur);
                    end
                    if (out_valid && out_ready) pend = 1'b0;
                end
            end
        end

        task automatic send(input logic [127:0] d, input logic md, input logic rnd);
            in_data  = d;
            in_valid = 1'b1;
`ifdef SUB_BYTES_SEQ_INV_SBOX_EN
            inv      = md;
`endif
            for (int w = 0; ; w++) begin
                if (rnd) out_ready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                if (in_ready) begin
                    sb_q.push_back('{data: ref_sub(d, md), cyc: cyc + 1});
                    @(posedge clk);
                    #1;
                    break;
                end
                if (w >= 200) begin
                    check(L, "accept_timeout", in_ready, 1);
                    break;
                end
                @(posedge clk);
                #1;
            end
            in_valid = 1'b0;
        endtask

        task automatic expect_out(input string name, input logic [127:0] lit);
            for (int w = 0; w < 64; w++) begin
                @(negedge clk);
                if (out_valid) break;
            end
            if (out_valid) check(L, name, out_data, lit);
            else check(L, {name, "_timeout"}, out_valid, 1);
            @(posedge clk);
            #1;
        endtask

        task automatic drain();
            out_ready = 1'b1;
            for (int w = 0; w < 200; w++) begin
                @(negedge clk);
                if (sb_q.size() == 0 && !out_valid) break;
            end
            check(L, "drain", {sb_q.size() == 0, out_valid}, 2'b10);
            @(posedge clk);
            #1;
        endtask

        initial begin
            logic [127:0] d;
            logic         md;
            rst_n     = 1'b0;
            in_valid  = 1'b0;
            out_ready = 1'b0;
            in_data   = '0;
`ifdef SUB_BYTES_SEQ_INV_SBOX_EN
            inv       = 1'b0;
`endif
            #1;
            check(L, "reset_flags", {out_valid, busy, in_ready}, 3'b001);
            check(L, "reset_data", out_data, '0);
            repeat (3) @(posedge clk);
            #1;
            rst_n     = 1'b1;
            out_ready = 1'b1;

            send(128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, 1'b0);
            expect_out("fips_vector", 128'hd42711aee0bf98f1b8b45de51e415230);
            send(128'h005301ff005301ff005301ff005301ff, 1'b0, 1'b0);
            expect_out("byte_pattern", 128'h63ed7c1663ed7c1663ed7c1663ed7c16);

            // Backpressure, then an output handshake coincident with a new input.
            out_ready = 1'b0;
            d = {$urandom, $urandom, $urandom, $urandom};
            send(d, 1'b0, 1'b0);
            expect_out("bp_result", ref_sub(d, 1'b0));
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                check(L, "bp_hold", {out_valid, in_ready, busy}, 3'b101);
                check(L, "bp_data", out_data, ref_sub(d, 1'b0));
                @(posedge clk);
                #1;
            end
            out_ready = 1'b1;
            send({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
            drain();

            // Reset on SUB beat 1 discards the state in flight.
            send({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
            if (BEATS > 1) begin
                @(posedge clk);
                #1;
            end
            rst_n = 1'b0;
            sb_q.delete();
            #1;
            check(L, "abort_flags", {out_valid, busy, in_ready}, 3'b001);
            check(L, "abort_data", out_data, '0);
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
            send(128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, 1'b0);
            expect_out("after_reset", 128'hd42711aee0bf98f1b8b45de51e415230);

`ifdef SUB_BYTES_SEQ_INV_SBOX_EN
            send(128'h63ed7c1663ed7c1663ed7c1663ed7c16, 1'b1, 1'b0);
            expect_out("inverse_pattern", 128'h005301ff005301ff005301ff005301ff);
            send(128'hd42711aee0bf98f1b8b45de51e415230, 1'b1, 1'b0);
            for (int k = 0; k < BEATS; k++) begin
                inv = ~inv;
                @(posedge clk);
                #1;
            end
            drain();
`endif

            for (int n = 0; n < 200; n++) begin
                repeat ($urandom_range(0, 2)) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
                d  = {$urandom, $urandom, $urandom, $urandom};
                md = 1'b0;
`ifdef SUB_BYTES_SEQ_INV_SBOX_EN
                md = 1'($urandom_range(0, 1));
`endif
                send(d, md, 1'b1);
            end
            drain();
            done_cnt++;
        end
    end

    initial begin
        for (int t = 0; t < 60000 && done_cnt < 5; t++) @(posedge clk);
        check(0, "all_lanes_done", done_cnt, 5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sub_bytes_seq.md
Name: sub_bytes_seq

Overview:
Sequential, parametrised AES SubBytes engine for the 128-bit AES state matrix. It substitutes LANES bytes per clock, so a full state takes 16/LANES substitution cycles. This trades area against latency for the round datapath. It uses a valid/ready handshake on input and output, holds its result under backpressure, and optionally supports inverse S-box for decryption.

Parameters:
- LANES, 4, number of parallel S-box instances; legal values 1, 2, 4, 8, 16; any other value is a compile-time error.
- BEATS, 16/LANES, derived localparam; substitution cycles per state; not user-overridable.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept a state this cycle
- in_data  input  128  state; byte 0 = [127:120], byte 15 = [7:0]
- inv  input  1  inverse mode select; present only with INV_SBOX_EN; sampled on input handshake
- out_valid  output  1  out_data holds a completed result
- out_ready  input  1  downstream accepts out_data
- out_data  output  128  substituted state, same byte order as in_data
- busy  output  1  high in SUB or DONE

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = IDLE; beat counter = 0; working register = 0.
  - Outputs: out_valid = 0, out_data = 0, busy = 0, in_ready = 1.
- Clock and reset: all state updates on clk rising edge; reset deassertion takes effect at the first edge after release.
- States: IDLE, SUB, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: load in_data into the working register, clear the beat counter, latch mode (with the macro), go to SUB.
- SUB:
  - in_ready = 0.
  - Each cycle, replace bytes [cnt*LANES .. cnt*LANES+LANES-1] of the working register with their S-box images.
  - cnt increments; after beat BEATS-1 go to DONE.
  - in_valid is ignored.
- DONE:
  - out_valid = 1; out_data = working register, held stable until the handshake.
  - On out_ready: out_valid drops next cycle unless a new state completes.
  - in_ready = out_ready in DONE, giving back-to-back operation. An input handshake coincident with the output handshake loads the new state and goes directly to SUB. Output handshake without input goes to IDLE.
- Latency: input handshake at edge N gives out_valid high from edge N+BEATS. With LANES=16 the result appears one cycle after acceptance.
- Throughput: one state per BEATS+1 cycles with out_ready held high.
- out_data is driven from the working register in every state (no output mux). Consumers must qualify it with out_valid.
- S-box:
  - Forward table is the FIPS-197 table implemented as a constant combinational case lookup per lane.
  - No file-based ROM initialisation and no external file dependency.
- Byte index arithmetic: cnt is $clog2(BEATS) bits wide, minimum 1 bit. With LANES=16, cnt is unused and always 0.
- Reset mid-operation: work in progress is discarded; no output is produced for the aborted state.
- Protocol:
  - out_valid never drops without a handshake.
  - out_data never changes while out_valid=1 & out_ready=0.

Optional Feature:
- Macro: SUB_BYTES_SEQ_INV_SBOX_EN.
- Defined:
  - Adds the inv port and an inverse FIPS-197 table per lane.
  - Mode is registered at input handshake and applies to the whole state.
  - Changing inv mid-operation has no effect.
- Undefined: no inv port, no inverse tables; forward substitution only.

Test Plan:
- LANES=4, in_data=193de3bea0f4e22b9ac68d2ae9f84808, out_ready=1 -> out_valid exactly 4 cycles after acceptance; out_data=d42711aee0bf98f1b8b45de51e415230; in_ready=0 during SUB.
- LANES=1 and LANES=16, in_data=00530 1FF repeated (bytes 00,53,01,FF x4) -> every group 63,ED,7C,16; latency 16 and 1 cycles respectively.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_data stable, out_valid held, in_ready=0. Then out_ready=1 with in_valid=1 -> both handshakes in the same cycle, next result after BEATS cycles.
- Reset: assert reset_n=0 on SUB beat 1 -> out_valid=0, out_data=0, in_ready=1 immediately. After release, a new state is processed correctly and no stale output appears.
- Macro defined, inv=1, in_data bytes 63,ED,7C,16 repeated -> 00,53,01,FF repeated. Toggling inv during SUB -> result unchanged.
- Random 1000 states, random valid/ready stalls, all legal LANES -> out_data equals the reference SubBytes model; no lost or duplicated transfers.
